// File: rtl/chip8_scanout.sv
// chip8_scanout: snapshots the 64x32 CHIP-8 framebuffer and streams it as
// 1-bit pixels in raster order over valid/ready, with integer upscaling by
// SCALE_X (columns) and SCALE_Y (rows).
// Optional feature macro: CHIP8_SCANOUT_FRAMECNT_EN adds a 16-bit count of
// completed frames on port frame_count.
module chip8_scanout #(
    parameter int SCALE_X = 1,
    parameter int SCALE_Y = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2047:0] display_in,
    input  logic          frame_start,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_pixel,
    output logic          out_sof,
    output logic          out_eol,
    output logic          out_eof,
    output logic          busy
`ifdef CHIP8_SCANOUT_FRAMECNT_EN
    ,
    output logic [15:0]   frame_count
`endif
);

    localparam int SXW = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
    localparam int SYW = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;
    localparam logic [SXW-1:0] SX_LAST = SXW'(SCALE_X - 1);
    localparam logic [SYW-1:0] SY_LAST = SYW'(SCALE_Y - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t          state_reg;
    logic [2047:0]   shadow_reg;
    logic [SXW-1:0]  sx_reg;
    logic [5:0]      px_reg;
    logic [SYW-1:0]  sy_reg;
    logic [4:0]      py_reg;
    logic            pending_reg;

    logic [SXW-1:0]  sx_next;
    logic [5:0]      px_next;
    logic [SYW-1:0]  sy_next;
    logic [4:0]      py_next;
    logic [10:0]     pix_idx_next;
    logic            eol_next;
    logic            eof_next;
    logic            handshake;

    assign handshake = out_valid && out_ready;

    // Cascaded replication counters: sx -> px -> sy -> py, no division needed.
    always_comb begin
        sx_next = sx_reg;
        px_next = px_reg;
        sy_next = sy_reg;
        py_next = py_reg;
        if (sx_reg == SX_LAST) begin
            sx_next = '0;
            if (px_reg == 6'd63) begin
                px_next = 6'd0;
                if (sy_reg == SY_LAST) begin
                    sy_next = '0;
                    py_next = py_reg + 5'd1;
                end else begin
                    sy_next = sy_reg + SYW'(1);
                end
            end else begin
                px_next = px_reg + 6'd1;
            end
        end else begin
            sx_next = sx_reg + SXW'(1);
        end
        // 2047 - (py*64 + px) is the bitwise complement of the 11-bit {py,px}
        pix_idx_next = ~{py_next, px_next};
        eol_next     = (px_next == 6'd63) && (sx_next == SX_LAST);
        eof_next     = eol_next && (py_next == 5'd31) && (sy_next == SY_LAST);
    end

    // Frame sequencing, snapshot capture and registered beat outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            shadow_reg  <= '0;
            sx_reg      <= '0;
            px_reg      <= '0;
            sy_reg      <= '0;
            py_reg      <= '0;
            pending_reg <= 1'b0;
            out_valid   <= 1'b0;
            out_pixel   <= 1'b0;
            out_sof     <= 1'b0;
            out_eol     <= 1'b0;
            out_eof     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (frame_start || pending_reg) begin
                        shadow_reg  <= display_in;
                        sx_reg      <= '0;
                        px_reg      <= '0;
                        sy_reg      <= '0;
                        py_reg      <= '0;
                        pending_reg <= 1'b0;
                        state_reg   <= STREAM;
                        busy        <= 1'b1;
                        out_valid   <= 1'b1;
                        out_pixel   <= display_in[2047];
                        out_sof     <= 1'b1;
                        out_eol     <= 1'b0;
                        out_eof     <= 1'b0;
                    end
                end
                STREAM: begin
                    // A request while streaming is remembered once; extras are dropped.
                    if (frame_start) begin
                        pending_reg <= 1'b1;
                    end
                    if (handshake) begin
                        if (out_eof) begin
                            state_reg <= IDLE;
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            out_pixel <= 1'b0;
                            out_sof   <= 1'b0;
                            out_eol   <= 1'b0;
                            out_eof   <= 1'b0;
                        end else begin
                            sx_reg    <= sx_next;
                            px_reg    <= px_next;
                            sy_reg    <= sy_next;
                            py_reg    <= py_next;
                            out_pixel <= shadow_reg[pix_idx_next];
                            out_sof   <= 1'b0;
                            out_eol   <= eol_next;
                            out_eof   <= eof_next;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef CHIP8_SCANOUT_FRAMECNT_EN
    // Count frames that complete their final handshake; reset-aborted frames never get here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_count <= 16'd0;
        end else if (state_reg == STREAM && handshake && out_eof) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_chip8_scanout.sv
// Testbench for chip8_scanout: two instances (1x1 and 2x2 scaling) share clock,
// reset and out_ready; a queue scoreboard holds the expected beat stream of
// every frame requested and is compared beat by beat while out_valid is high.
module tb_chip8_scanout;

    typedef struct packed {
        logic pixel;
        logic sof;
        logic eol;
        logic eof;
    } beat_t;

    logic          clk;
    logic          reset;
    logic [2047:0] display;
    logic          fs1, fs2;
    logic          out_ready;
    logic          v1, p1, s1, l1, e1, b1;
    logic          v2, p2, s2, l2, e2, b2;
`ifdef CHIP8_SCANOUT_FRAMECNT_EN
    logic [15:0]   fc1, fc2;
`endif

    logic          sel;
    logic          rand_ready;
    beat_t         exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            beat_cnt = 0;
    int            frames_done = 0;
    int            cyc = 0;
    int            eof_cyc = 0;
    int            sof_gap = 0;

    chip8_scanout #(.SCALE_X(1), .SCALE_Y(1)) dut1 (
        .clk(clk), .reset(reset), .display_in(display), .frame_start(fs1),
        .out_valid(v1), .out_ready(out_ready), .out_pixel(p1), .out_sof(s1),
        .out_eol(l1), .out_eof(e1), .busy(b1)
`ifdef CHIP8_SCANOUT_FRAMECNT_EN
        , .frame_count(fc1)
`endif
    );

    chip8_scanout #(.SCALE_X(2), .SCALE_Y(2)) dut2 (
        .clk(clk), .reset(reset), .display_in(display), .frame_start(fs2),
        .out_valid(v2), .out_ready(out_ready), .out_pixel(p2), .out_sof(s2),
        .out_eol(l2), .out_eof(e2), .busy(b2)
`ifdef CHIP8_SCANOUT_FRAMECNT_EN
        , .frame_count(fc2)
`endif
    );

    logic  m_valid;
    beat_t m_beat;
    assign m_valid = sel ? v2 : v1;
    assign m_beat  = sel ? {p2, s2, l2, e2} : {p1, s1, l1, e1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sink ready: constant 1 or random, changed just after each edge.
    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard compare on the falling edge; the front entry is compared on
    // every valid cycle, so a stalled beat must stay equal to it.
    always @(negedge clk) begin
        if (m_valid) begin
            if (exp_q.size() == 0) begin
                check("beat_expected", 32'(m_valid), 32'd0);
            end else begin
                check("beat", 32'(m_beat), 32'(exp_q[0]));
                if (out_ready) begin
                    if (exp_q[0].sof) sof_gap = cyc - eof_cyc;
                    if (exp_q[0].eof) begin
                        eof_cyc = cyc;
                        frames_done++;
                        $display("frame %0d done dut=%0d beats_total=%0d", frames_done, sel ? 2 : 1, beat_cnt + 1);
                    end
                    void'(exp_q.pop_front());
                    beat_cnt++;
                end
            end
        end
    end

    task automatic push_frame(input logic [2047:0] img, input int scx, input int scy);
        beat_t b;
        for (int py = 0; py < 32; py++)
            for (int sy = 0; sy < scy; sy++)
                for (int px = 0; px < 64; px++)
                    for (int sx = 0; sx < scx; sx++) begin
                        b.pixel = img[2047 - (py * 64 + px)];
                        b.sof   = (py == 0 && sy == 0 && px == 0 && sx == 0);
                        b.eol   = (px == 63 && sx == scx - 1);
                        b.eof   = b.eol && py == 31 && sy == scy - 1;
                        exp_q.push_back(b);
                    end
    endtask

    task automatic pulse_start(input int which);
        @(posedge clk); #1;
        if (which == 2) fs2 = 1'b1; else fs1 = 1'b1;
        @(posedge clk); #1;
        fs1 = 1'b0;
        fs2 = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int limit);
        int base = beat_cnt;
        int t = 0;
        while (beat_cnt - base < n && t < limit) begin
            @(posedge clk); #1;
            t++;
        end
        check("beats_reached", 32'(beat_cnt - base), 32'(n));
    endtask

    task automatic wait_drain(input int limit);
        int t = 0;
        while (exp_q.size() != 0 && t < limit) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic rand_img(output logic [2047:0] img);
        for (int i = 0; i < 64; i++) img[i * 32 +: 32] = $urandom;
    endtask

    logic [2047:0] img;

    initial begin
        reset = 1'b0; display = '0; fs1 = 1'b0; fs2 = 1'b0;
        out_ready = 1'b1; rand_ready = 1'b0; sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", 32'({v1, p1, s1, l1, e1, b1, v2, p2, s2, l2, e2, b2}), 32'd0);
`ifdef CHIP8_SCANOUT_FRAMECNT_EN
        check("reset_fcnt", 32'({fc1, fc2}), 32'd0);
`endif
        reset = 1'b1;

        // 1x1, corner pixels lit, ready held high
        img = '0; img[2047] = 1'b1; img[0] = 1'b1;
        display = img;
        push_frame(img, 1, 1);
        pulse_start(1);
        check("busy_stream", 32'(b1), 32'd1);
        wait_drain(3000);
        check("frames_corner", 32'(frames_done), 32'd1);

        // random ready, framebuffer cleared mid-frame
        rand_img(img);
        display = img;
        rand_ready = 1'b1;
        push_frame(img, 1, 1);
        pulse_start(1);
        wait_beats(500, 3000);
        display = '0;
        wait_drain(12000);
        rand_ready = 1'b0;
        check("frames_random", 32'(frames_done), 32'd2);

        // requests at beat 100 and 200: one extra frame, one idle cycle gap
        rand_img(img);
        display = img;
        push_frame(img, 1, 1);
        pulse_start(1);
        wait_beats(100, 500);
        push_frame(img, 1, 1);
        pulse_start(1);
        wait_beats(100, 500);
        pulse_start(1);
        wait_drain(6000);
        repeat (20) @(posedge clk);
        #1;
        check("frames_pending", 32'(frames_done), 32'd4);
        check("pending_gap", 32'(sof_gap), 32'd2);
        check("idle_after", 32'({v1, b1}), 32'd0);

        // 2x2 scaling, only (1,0) lit
        sel = 1'b1;
        img = '0; img[2046] = 1'b1;
        display = img;
        push_frame(img, 2, 2);
        pulse_start(2);
        wait_drain(10000);
        check("frames_scaled", 32'(frames_done), 32'd5);
        @(posedge clk); #1;
        sel = 1'b0;

        // reset mid-stream aborts; next frame restarts at sof
        rand_img(img);
        display = img;
        push_frame(img, 1, 1);
        pulse_start(1);
        wait_beats(300, 1000);
        #1;
        reset = 1'b0;
        #1;
        check("reset_mid", 32'({v1, p1, s1, l1, e1, b1}), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("no_beats_after_reset", 32'(v1), 32'd0);
        push_frame(img, 1, 1);
        pulse_start(1);
        wait_drain(3000);
        check("frames_after_reset", 32'(frames_done), 32'd6);

`ifdef CHIP8_SCANOUT_FRAMECNT_EN
        // three frames, then a reset-aborted fourth
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int f = 0; f < 3; f++) begin
            push_frame(img, 1, 1);
            pulse_start(1);
            wait_drain(3000);
            @(posedge clk); #1;
        end
        check("fcnt_three", 32'(fc1), 32'd3);
        push_frame(img, 1, 1);
        pulse_start(1);
        wait_beats(100, 500);
        #1;
        reset = 1'b0;
        #1;
        check("fcnt_reset", 32'(fc1), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("fcnt_aborted", 32'(fc1), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
